imem_port_arbiter: RTL

Arbiter and access sequencer for the byte-wide instruction memory (8-bit cells, big-endian 32-bit words). It shares the memory between the CPU fetch port and the program-loader write port. Each 32-bit request becomes four sequential byte accesses. It assembles read words and splits write words, and flags misaligned or out-of-range addresses. It sits between the PC/fetch logic and loader on one side and the byte memory array on the other.

---
 rtl/imem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide instruction memory between the fetch port and the loader.
// Each 32-bit request becomes four big-endian byte accesses; bad addresses are acked with an error.
module imem_port_arbiter #(
  parameter int ADDR_W = 7
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_req,
  input  logic [31:0]       i_fetch_addr,
  output logic              o_fetch_ack,
  output logic [31:0]       o_fetch_data,
  input  logic              i_load_req,
  input  logic [31:0]       i_load_addr,
  input  logic [31:0]       i_load_data,
  output logic              o_load_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy,
  output logic              o_addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  localparam logic KIND_FETCH = 1'b0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [1:0]        r_idx;
  logic              r_kind;
  logic              r_last;
  logic [23:0]       r_data;
  logic [23:0]       r_stage;
  logic [31:0]       r_fetch_data;
  logic              r_fetch_ack, r_load_ack, r_busy, r_addr_err, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;

  logic        w_gnt_load;
  logic [31:0] w_gnt_addr;
  logic        w_addr_bad;
  logic [7:0]  w_next_lane;

  // On a tie the requester that did not win last time gets the memory.
  assign w_gnt_load = i_load_req & (~i_fetch_req | (r_last == KIND_FETCH));
  assign w_gnt_addr = w_gnt_load ? i_load_addr : i_fetch_addr;
  assign w_addr_bad = (w_gnt_addr[1:0] != 2'b00) | (|w_gnt_addr[31:ADDR_W]);

  always_comb begin
    w_next_lane = 8'h00;
    case (r_idx)
      2'd0:    w_next_lane = r_data[23:16];
      2'd1:    w_next_lane = r_data[15:8];
      default: w_next_lane = r_data[7:0];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 2'd0;
      r_kind       <= KIND_FETCH;
      r_last       <= KIND_FETCH;
      r_data       <= 24'h0;
      r_stage      <= 24'h0;
      r_fetch_data <= 32'h0;
      r_fetch_ack  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_busy       <= 1'b0;
      r_addr_err   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fetch_req | i_load_req) begin
            r_kind <= w_gnt_load;
            r_last <= w_gnt_load;
            r_data <= i_load_data[23:0];
            r_busy <= 1'b1;
            if (w_addr_bad) begin
              r_state     <= S_DONE;
              r_addr_err  <= 1'b1;
              r_fetch_ack <= ~w_gnt_load;
              r_load_ack  <= w_gnt_load;
            end else begin
              r_state     <= S_ACCESS;
              r_idx       <= 2'd0;
              r_mem_addr  <= w_gnt_addr[ADDR_W-1:0];
              r_mem_we    <= w_gnt_load;
              r_mem_wdata <= w_gnt_load ? i_load_data[31:24] : 8'h00;
            end
          end
        end
        S_ACCESS: begin
          if (r_kind == KIND_FETCH) begin
            case (r_idx)
              2'd0:    r_stage[23:16] <= i_mem_rdata;
              2'd1:    r_stage[15:8]  <= i_mem_rdata;
              2'd2:    r_stage[7:0]   <= i_mem_rdata;
              default: r_fetch_data   <= {r_stage, i_mem_rdata};
            endcase
          end
          if (r_idx == 2'd3) begin
            r_state     <= S_DONE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_fetch_ack <= (r_kind == KIND_FETCH);
            r_load_ack  <= (r_kind != KIND_FETCH);
          end else begin
            r_idx       <= r_idx + 2'd1;
            r_mem_addr  <= r_mem_addr + ADDR_ONE;
            r_mem_wdata <= (r_kind != KIND_FETCH) ? w_next_lane : 8'h00;
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_idx       <= 2'd0;
          r_busy      <= 1'b0;
          r_fetch_ack <= 1'b0;
          r_load_ack  <= 1'b0;
          r_addr_err  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_fetch_ack  = r_fetch_ack;
  assign o_fetch_data = r_fetch_data;
  assign o_load_ack   = r_load_ack;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_we     = r_mem_we;
  assign o_busy       = r_busy;
  assign o_addr_err   = r_addr_err;

endmodule
